// File: rtl/param_port_lookup.sv
// Output-port lookup for the user data path: rewrites the IOQ header destination
// mask from the source port (fixed MAC/CPU pairing or a programmable table), then queues words.
module param_port_lookup #(
    parameter int unsigned DATA_WIDTH         = 64,
    parameter int unsigned CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int unsigned NUM_PORTS          = 8,
    parameter int unsigned IO_QUEUE_STAGE_NUM = 8'hFF,
    parameter int unsigned SRC_PORT_POS       = 16,
    parameter int unsigned DST_PORT_POS       = 0,
    parameter int unsigned FIFO_DEPTH_BITS    = 2,
    parameter bit          DEFAULT_MODE       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  reg_wr,
    input  logic [4:0]            reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int unsigned CNT_W = FIFO_DEPTH_BITS + 1;
    localparam int unsigned IDX_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam logic [4:0]  ADDR_CTRL = 5'd16;
    localparam logic [4:0]  ADDR_PKT  = 5'd17;
    localparam logic [4:0]  ADDR_MISS = 5'd18;

    typedef enum logic {HDRS = 1'b0, PKT = 1'b1} state_t;

    state_t                 state;
    logic                   hdr_done;
    logic                   mode;
    logic [15:0]            dflt_mask;
    logic [NUM_PORTS-1:0]   dst_table [NUM_PORTS];
    logic [31:0]            pkt_cnt;
    logic [31:0]            miss_cnt;

    logic [DATA_WIDTH-1:0]      fifo_data [DEPTH];
    logic [CTRL_WIDTH-1:0]      fifo_ctrl [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]           count;

    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic                  rd_en_c;
    logic                  wr_en_c;
    logic                  is_hdr_c;
    logic                  lookup_miss_c;
    logic                  tbl_wr_c;
    logic [15:0]           src_c;
    logic [IDX_W-1:0]      src_idx_c;
    logic [15:0]           calc_mask_c;
    logic [15:0]           final_mask_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic                  unused_wdata_c;

    // A word arriving while full is only taken when a read frees a slot the same cycle.
    assign fifo_full_c  = (count == CNT_W'(DEPTH));
    assign fifo_empty_c = (count == '0);
    assign rd_en_c      = out_rdy && !fifo_empty_c;
    assign wr_en_c      = in_wr && (!fifo_full_c || rd_en_c);
    assign in_rdy       = (CNT_W'(DEPTH) - count) > CNT_W'(1);

    assign tbl_wr_c       = reg_wr && (32'(reg_addr) < NUM_PORTS);
    assign unused_wdata_c = ^reg_wdata;

    // Destination lookup for the IOQ module header.
    always_comb begin
        src_c        = in_data[SRC_PORT_POS +: 16];
        src_idx_c    = src_c[IDX_W-1:0];
        calc_mask_c  = '0;
        if (!mode) begin
            if (src_c[0]) begin
                calc_mask_c = 16'(1) << (src_c - 16'd1);
            end else if ((32'(src_c) + 32'd1) < NUM_PORTS) begin
                calc_mask_c = 16'(1) << (src_c + 16'd1);
            end
        end else begin
            calc_mask_c = 16'(dst_table[src_idx_c]);
        end
        lookup_miss_c = (32'(src_c) >= NUM_PORTS) || (calc_mask_c == '0);
        final_mask_c  = lookup_miss_c ? dflt_mask : calc_mask_c;
        is_hdr_c      = wr_en_c && (state == HDRS) && !hdr_done &&
                        (in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
        word_c        = in_data;
        if (is_hdr_c) begin
            word_c[DST_PORT_POS +: 16] = final_mask_c;
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (32'(reg_addr) < NUM_PORTS) begin
            reg_rdata = 32'(dst_table[reg_addr[IDX_W-1:0]]);
        end else begin
            case (reg_addr)
                ADDR_CTRL: reg_rdata = {dflt_mask, 15'd0, mode};
                ADDR_PKT:  reg_rdata = pkt_cnt;
                ADDR_MISS: reg_rdata = miss_cnt;
                default:   reg_rdata = '0;
            endcase
        end
    end

    // Packet framing: only the first IOQ header seen before the payload is rewritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HDRS;
            hdr_done <= 1'b0;
        end else if (wr_en_c) begin
            case (state)
                HDRS: begin
                    if (in_ctrl == '0) begin
                        state    <= PKT;
                        hdr_done <= 1'b0;
                    end else if (is_hdr_c) begin
                        hdr_done <= 1'b1;
                    end
                end
                PKT: begin
                    if (in_ctrl != '0) begin
                        state <= HDRS;
                    end
                end
                default: state <= HDRS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode      <= DEFAULT_MODE;
            dflt_mask <= 16'h0002;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                dst_table[i] <= '0;
            end
        end else begin
            if (tbl_wr_c) begin
                dst_table[reg_addr[IDX_W-1:0]] <= reg_wdata[NUM_PORTS-1:0];
            end
            if (reg_wr && (reg_addr == ADDR_CTRL)) begin
                mode      <= reg_wdata[0];
                dflt_mask <= reg_wdata[31:16];
            end
        end
    end

    // A clear coincident with an increment leaves the counter at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (reg_wr && (reg_addr == ADDR_PKT)) begin
                pkt_cnt <= '0;
            end else if (is_hdr_c) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (reg_wr && (reg_addr == ADDR_MISS)) begin
                miss_cnt <= '0;
            end else if (is_hdr_c && lookup_miss_c) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            fifo_data[wr_ptr] <= word_c;
            fifo_ctrl[wr_ptr] <= in_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            end
            if (rd_en_c) begin
                rd_ptr   <= rd_ptr + FIFO_DEPTH_BITS'(1);
                out_data <= fifo_data[rd_ptr];
                out_ctrl <= fifo_ctrl[rd_ptr];
            end
            out_wr <= rd_en_c;
            case ({wr_en_c, rd_en_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_param_port_lookup.sv
// Randomized packet-level bench for param_port_lookup: expected words and register
// values come from a packet/register model evaluated in stimulus order.
module tb_param_port_lookup;

    localparam int unsigned DW       = 64;
    localparam int unsigned CW       = 8;
    localparam int unsigned NP       = 8;
    localparam bit          DEF_MODE = 1'b0;
    localparam logic [7:0]  IOQ      = 8'hFF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy;
    logic          reg_wr;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;

    always #5 clk = ~clk;

    param_port_lookup #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_PORTS(NP), .IO_QUEUE_STAGE_NUM(8'hFF),
        .SRC_PORT_POS(16), .DST_PORT_POS(0), .FIFO_DEPTH_BITS(2), .DEFAULT_MODE(DEF_MODE)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    typedef struct {
        bit          has_word;
        logic [63:0] data;
        logic [7:0]  ctrl;
        bit          has_reg;
        bit          is_read;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } stim_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
    } word_t;

    stim_t stim[$];
    word_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    accepted = 0;
    bit    hold_out = 1'b0;

    bit          m_mode;
    logic [15:0] m_dflt;
    logic [15:0] m_tbl [16];
    logic [31:0] m_pkt;
    logic [31:0] m_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = DEF_MODE;
        m_dflt = 16'h0002;
        for (int i = 0; i < 16; i++) m_tbl[i] = '0;
        m_pkt  = '0;
        m_miss = '0;
    endfunction

    function automatic void model_write(input logic [4:0] addr, input logic [31:0] wd);
        if (int'(addr) < int'(NP)) m_tbl[addr] = wd[15:0] & 16'((1 << NP) - 1);
        else if (addr == 5'd16) begin
            m_mode = wd[0];
            m_dflt = wd[31:16];
        end
        else if (addr == 5'd17) m_pkt = '0;
        else if (addr == 5'd18) m_miss = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        if (int'(addr) < int'(NP)) return 32'(m_tbl[addr]);
        if (addr == 5'd16) return {m_dflt, 15'd0, m_mode};
        if (addr == 5'd17) return m_pkt;
        if (addr == 5'd18) return m_miss;
        return '0;
    endfunction

    // Routing rule: MAC 2k <-> CPU 2k+1 in pairing mode, table entry in table mode.
    function automatic logic [15:0] lookup(input int src, output bit miss);
        logic [15:0] m = '0;
        if (src < int'(NP)) begin
            if (m_mode) m = m_tbl[src];
            else if (src % 2 == 1) m = 16'(1) << (src - 1);
            else if (src + 1 < int'(NP)) m = 16'(1) << (src + 1);
        end
        miss = (m == '0);
        return miss ? m_dflt : m;
    endfunction

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] wd);
        stim_t s;
        s.has_word = 0; s.data = '0; s.ctrl = '0;
        s.has_reg = 1; s.is_read = 0; s.addr = addr; s.wdata = wd;
        model_write(addr, wd);
        stim.push_back(s);
    endtask

    task automatic reg_read(input logic [4:0] addr);
        stim_t s;
        s.has_word = 0; s.data = '0; s.ctrl = '0;
        s.has_reg = 1; s.is_read = 1; s.addr = addr; s.wdata = model_read(addr);
        stim.push_back(s);
    endtask

    // Packet = module headers (nonzero ctrl), ndata payload words (ctrl 0), one end word.
    // Only the first IOQ header ahead of the payload gets its destination rewritten.
    task automatic send_pkt(input int src, input bit ff_first, input int n_extra, input int ndata,
                            input bit with_reg, input logic [4:0] raddr, input logic [31:0] rwd);
        stim_t       w[$];
        stim_t       s;
        word_t       e;
        int          nh = 1 + n_extra;
        int          hit = -1;
        bit          miss;
        for (int i = 0; i < nh + ndata + 1; i++) begin
            s.has_word = 1; s.has_reg = 0; s.is_read = 0; s.addr = '0; s.wdata = '0;
            s.data = {$urandom, $urandom};
            if (i < nh) begin
                if (i == 0) s.ctrl = ff_first ? IOQ : 8'($urandom_range(1, 254));
                else        s.ctrl = ($urandom_range(0, 2) == 0) ? IOQ : 8'($urandom_range(1, 254));
                s.data[31:16] = 16'(src);
            end else if (i < nh + ndata) begin
                s.ctrl = '0;
            end else begin
                s.ctrl = 8'($urandom_range(1, 255));
            end
            w.push_back(s);
        end
        for (int i = 0; i < nh; i++) begin
            if (hit < 0 && w[i].ctrl == IOQ) hit = i;
        end
        foreach (w[i]) begin
            e.data = w[i].data;
            e.ctrl = w[i].ctrl;
            if (i == hit) begin
                e.data[15:0] = lookup(int'(w[i].data[31:16]), miss);
                m_pkt++;
                if (miss) m_miss++;
            end
            exp_q.push_back(e);
        end
        if (with_reg) begin
            w[0].has_reg = 1; w[0].addr = raddr; w[0].wdata = rwd;
            model_write(raddr, rwd);
        end
        foreach (w[i]) stim.push_back(w[i]);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (stim.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(stim.size() + exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Driver: one stimulus entry per cycle, words only while in_rdy.
    initial begin
        stim_t s;
        in_wr = 0; in_data = '0; in_ctrl = '0;
        reg_wr = 0; reg_addr = '0; reg_wdata = '0;
        forever begin
            @(negedge clk);
            in_wr  = 0;
            reg_wr = 0;
            if (stim.size() != 0) begin
                s = stim[0];
                if (!s.has_word || in_rdy) begin
                    s = stim.pop_front();
                    if (s.has_word) begin
                        in_wr = 1; in_data = s.data; in_ctrl = s.ctrl;
                        accepted++;
                    end
                    if (s.has_reg) begin
                        reg_addr = s.addr; reg_wdata = s.wdata; reg_wr = !s.is_read;
                        if (s.is_read) begin
                            #1;
                            check($sformatf("reg[%0d]", s.addr), 64'(reg_rdata), 64'(s.wdata));
                        end
                    end
                end
            end
        end
    end

    // Output monitor and downstream backpressure.
    initial begin
        word_t e;
        out_rdy = 0;
        forever begin
            @(negedge clk);
            if (reset_n && out_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_wr), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                end
            end
            out_rdy = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int base;
        reset_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        reset_n = 1;
        for (int a = 0; a < 19; a++) reg_read(5'(a));
        reg_read(5'd20);
        wait_idle(200);

        // Pairing mode, then unroutable sources.
        send_pkt(4, 1, 0, 2, 0, '0, '0);
        send_pkt(3, 1, 1, 1, 0, '0, '0);
        reg_read(5'd17); reg_read(5'd18);
        send_pkt(9, 1, 0, 2, 0, '0, '0);
        send_pkt(20, 1, 0, 1, 0, '0, '0);
        reg_read(5'd18);
        wait_idle(500);

        // Table mode; unused table bits and unmapped addresses.
        reg_write(5'd2, 32'h55);
        reg_write(5'd16, 32'h0002_0001);
        send_pkt(2, 1, 0, 2, 0, '0, '0);
        send_pkt(5, 1, 0, 2, 0, '0, '0);
        reg_read(5'd18);
        reg_write(5'd1, 32'hFFFF_FFFF); reg_read(5'd1);
        reg_write(5'd25, 32'h1234_5678); reg_read(5'd25); reg_read(5'd16);
        wait_idle(500);

        // Backpressure: in_rdy drops with three words queued.
        hold_out = 1;
        repeat (2) @(negedge clk);
        base = accepted;
        for (int p = 0; p < 3; p++) send_pkt(p, 1, 0, 2, 0, '0, '0);
        repeat (10) @(negedge clk);
        #2;
        check("burst_in_rdy", 64'(in_rdy), 64'd0);
        check("burst_queued", 64'(accepted - base), 64'd3);
        check("burst_out_wr", 64'(out_wr), 64'd0);
        hold_out = 0;
        wait_idle(1000);

        // Register writes coincident with header lookups.
        send_pkt(2, 1, 0, 1, 1, 5'd2, 32'h0F);
        send_pkt(2, 1, 0, 1, 0, '0, '0);
        send_pkt(2, 1, 0, 1, 1, 5'd17, 32'h0);
        reg_read(5'd17);
        send_pkt(6, 1, 0, 1, 1, 5'd18, 32'h0);
        reg_read(5'd17); reg_read(5'd18);
        wait_idle(500);

        // Random traffic with random register writes.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 99) < 15) begin
                case ($urandom_range(0, 4))
                    0: reg_write(5'd16, {16'($urandom), 15'd0, 1'($urandom)});
                    1: reg_write(5'($urandom_range(17, 18)), $urandom);
                    2: reg_write(5'd25, $urandom);
                    default: reg_write(5'($urandom_range(0, NP - 1)),
                                       ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
                endcase
            end else begin
                send_pkt($urandom_range(0, 19), $urandom_range(0, 4) != 0,
                         $urandom_range(0, 2), $urandom_range(1, 3), 0, '0, '0);
            end
            if (it % 25 == 24) begin
                reg_read(5'd16); reg_read(5'd17); reg_read(5'd18);
            end
        end
        wait_idle(6000);
        for (int a = 0; a < 19; a++) reg_read(5'(a));
        wait_idle(200);

        // Reset in the middle of a packet.
        reg_write(5'd16, 32'h0004_0001);
        reg_write(5'd2, 32'h33);
        send_pkt(4, 1, 1, 8, 0, '0, '0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (out_wr) break;
        end
        check("pre_reset_out_wr", 64'(out_wr), 64'd1);
        reset_n = 0;
        #1;
        check("mid_rst_out_wr", 64'(out_wr), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        stim.delete();
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        reg_read(5'd2); reg_read(5'd16); reg_read(5'd17); reg_read(5'd18);
        wait_idle(100);
        reset_n = 1;
        send_pkt(4, 1, 0, 2, 0, '0, '0);
        send_pkt(1, 1, 0, 2, 0, '0, '0);
        reg_read(5'd17); reg_read(5'd18);
        wait_idle(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
